// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: ROB/LSQ entry layouts, commit FSM states
// and the committed-store buffer entry.
package commit_unit_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int TAG_W  = 6;

    typedef logic [WORD_W-1:0] MemoryWord;
    typedef logic [REG_W-1:0]  Register;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } commit_state_t;

    typedef struct packed {
        logic regwr;
        logic memwr;
        logic memrd;
    } ctrl_bits_t;

    typedef struct packed {
        logic       ready;
        tag_t       tag;
        Register    rd;
        MemoryWord  value;
        ctrl_bits_t ctrl_bits;
        logic       mispredict;
        MemoryWord  target;
    } rob_entry;

    typedef struct packed {
        tag_t      tag;
        MemoryWord address;
        MemoryWord value;
    } lsq_entry;

    typedef struct packed {
        MemoryWord addr;
        MemoryWord data;
    } sb_entry;

endpackage

// File: rtl/commit_unit_store_buffer.sv
// Committed-store FIFO: accepts a lane-ordered push vector (compacted into
// consecutive slots) and drains its head through a valid/ready handshake.
module store_buffer
    import commit_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NPUSH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NPUSH-1:0]           push_en,
    input  sb_entry [NPUSH-1:0]        push_entry,
    input  logic                       pop_ready,
    output logic                       valid,
    output sb_entry                    head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    sb_entry        mem_q [DEPTH];
    sb_entry        mem_d [DEPTH];
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           pop;

    assign valid = (count_q != '0);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[head_q];
    assign pop   = valid && pop_ready;

    // The commit logic guarantees count + pushes never exceeds DEPTH.
    always_comb begin
        logic [PW-1:0] wr_ptr;
        logic [CW-1:0] push_n;
        mem_d  = mem_q;
        wr_ptr = tail_q;
        push_n = '0;
        for (int i = 0; i < NPUSH; i++) begin
            if (push_en[i]) begin
                mem_d[wr_ptr] = push_entry[i];
                wr_ptr        = wr_ptr + PW'(1);
                push_n        = push_n + CW'(1);
            end
        end
        tail_d  = wr_ptr;
        head_d  = head_q + PW'(pop);
        count_d = count_q + push_n - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

endmodule

// File: rtl/commit_unit.sv
// Multi-wide in-order commit: picks the committing prefix of the ROB window,
// dequeues matching LSQ entries, buffers stores and flushes on mispredicts.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int RETIRE_WIDTH = 2,
    parameter int SB_DEPTH     = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  rob_entry [RETIRE_WIDTH-1:0]         rob_head,
    input  lsq_entry [RETIRE_WIDTH-1:0]         lsq_head,
    output logic [RETIRE_WIDTH-1:0]             regwr,
    output Register [RETIRE_WIDTH-1:0]          rd,
    output MemoryWord [RETIRE_WIDTH-1:0]        value,
    output logic [RETIRE_WIDTH-1:0]             victim,
    output logic [$clog2(RETIRE_WIDTH+1)-1:0]   rob_retire_count,
    output logic [$clog2(RETIRE_WIDTH+1)-1:0]   lsq_retire_count,
    output logic                                flush,
    output MemoryWord                           redirect_pc,
    output logic                                sb_valid,
    output MemoryWord                           sb_addr,
    output MemoryWord                           sb_data,
    input  logic                                sb_ready,
    output logic                                sb_empty
);

    localparam int CNT_W  = $clog2(RETIRE_WIDTH+1);
    localparam int SLOT_W = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;
    localparam int SBC_W  = $clog2(SB_DEPTH+1);

    commit_state_t                  state_q, state_d;
    logic [RETIRE_WIDTH-1:0]        commit;
    logic [RETIRE_WIDTH-1:0]        push_en;
    sb_entry [RETIRE_WIDTH-1:0]     push_entry;
    logic [CNT_W-1:0]               rob_cnt, lsq_cnt;
    logic [SBC_W-1:0]               sb_count;
    logic                           mp_commit;
    MemoryWord                      mp_target;
    sb_entry                        sb_head;

    logic [RETIRE_WIDTH-1:0]        regwr_d, regwr_q;
    Register [RETIRE_WIDTH-1:0]     rd_d, rd_q;
    MemoryWord [RETIRE_WIDTH-1:0]   value_d, value_q;
    MemoryWord                      redirect_d, redirect_q;

    // Walk lanes oldest-first; the first lane that cannot commit (or a
    // committing mispredict) blocks every younger lane.
    always_comb begin
        logic              blocked;
        logic              is_mem;
        logic              lane_ok;
        logic [SLOT_W-1:0] slot;
        int                stores;
        commit     = '0;
        push_en    = '0;
        push_entry = '0;
        rob_cnt    = '0;
        lsq_cnt    = '0;
        mp_commit  = 1'b0;
        mp_target  = '0;
        stores     = 0;
        blocked    = (state_q != RUN);
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            slot    = SLOT_W'(lsq_cnt);
            is_mem  = rob_head[i].ctrl_bits.memwr || rob_head[i].ctrl_bits.memrd;
            lane_ok = !blocked && rob_head[i].ready;
            if (is_mem && (lsq_head[slot].tag != rob_head[i].tag)) begin
                lane_ok = 1'b0;
            end
            // Space check sees only the registered count, never this cycle's pop.
            if (rob_head[i].ctrl_bits.memwr && ((int'(sb_count) + stores) >= SB_DEPTH)) begin
                lane_ok = 1'b0;
            end
            if (lane_ok) begin
                commit[i] = 1'b1;
                rob_cnt   = rob_cnt + CNT_W'(1);
                if (is_mem) begin
                    lsq_cnt = lsq_cnt + CNT_W'(1);
                end
                if (rob_head[i].ctrl_bits.memwr) begin
                    push_en[i]         = 1'b1;
                    push_entry[i].addr = lsq_head[slot].address;
                    push_entry[i].data = lsq_head[slot].value;
                    stores             = stores + 1;
                end
                if (rob_head[i].mispredict) begin
                    mp_commit = 1'b1;
                    mp_target = rob_head[i].target;
                    blocked   = 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = RUN;
        redirect_d = '0;
        if (state_q == RUN && mp_commit) begin
            state_d    = FLUSH;
            redirect_d = mp_target;
        end
    end

    for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_lane
        assign regwr_d[gi] = commit[gi] && rob_head[gi].ctrl_bits.regwr;
        assign rd_d[gi]    = regwr_d[gi] ? rob_head[gi].rd    : '0;
        assign value_d[gi] = regwr_d[gi] ? rob_head[gi].value : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            regwr_q    <= '0;
            rd_q       <= '0;
            value_q    <= '0;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            regwr_q    <= regwr_d;
            rd_q       <= rd_d;
            value_q    <= value_d;
            redirect_q <= redirect_d;
        end
    end

    store_buffer #(
        .DEPTH (SB_DEPTH),
        .NPUSH (RETIRE_WIDTH)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .push_en    (push_en),
        .push_entry (push_entry),
        .pop_ready  (sb_ready),
        .valid      (sb_valid),
        .head       (sb_head),
        .count      (sb_count),
        .empty      (sb_empty)
    );

    assign regwr            = regwr_q;
    assign rd               = rd_q;
    assign value            = value_q;
    assign victim           = regwr_q;
    assign rob_retire_count = rob_cnt;
    assign lsq_retire_count = lsq_cnt;
    assign flush            = (state_q == FLUSH);
    assign redirect_pc      = redirect_q;
    assign sb_addr          = sb_head.addr;
    assign sb_data          = sb_head.data;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: ALU/memory commit, in-order stalls, store
// buffer drain and full stall, mispredict flush, and async reset mid-flush.
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic                clk;
    logic                reset;
    rob_entry [1:0]      rob_head;
    lsq_entry [1:0]      lsq_head;
    logic [1:0]          regwr;
    Register [1:0]       rd;
    MemoryWord [1:0]     value;
    logic [1:0]          victim;
    logic [1:0]          rob_retire_count;
    logic [1:0]          lsq_retire_count;
    logic                flush;
    MemoryWord           redirect_pc;
    logic                sb_valid;
    MemoryWord           sb_addr;
    MemoryWord           sb_data;
    logic                sb_ready;
    logic                sb_empty;

    int checks   = 0;
    int failures = 0;

    commit_unit #(
        .RETIRE_WIDTH (2),
        .SB_DEPTH     (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rob_head         (rob_head),
        .lsq_head         (lsq_head),
        .regwr            (regwr),
        .rd               (rd),
        .value            (value),
        .victim           (victim),
        .rob_retire_count (rob_retire_count),
        .lsq_retire_count (lsq_retire_count),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .sb_valid         (sb_valid),
        .sb_addr          (sb_addr),
        .sb_data          (sb_data),
        .sb_ready         (sb_ready),
        .sb_empty         (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic rob_entry mk_rob(input logic rdy, input logic [5:0] tag,
                                        input logic [4:0] rdn, input logic [31:0] val,
                                        input logic rw, input logic mw, input logic mr,
                                        input logic mp, input logic [31:0] tgt);
        rob_entry e;
        e.ready           = rdy;
        e.tag             = tag;
        e.rd              = rdn;
        e.value           = val;
        e.ctrl_bits.regwr = rw;
        e.ctrl_bits.memwr = mw;
        e.ctrl_bits.memrd = mr;
        e.mispredict      = mp;
        e.target          = tgt;
        return e;
    endfunction

    function automatic lsq_entry mk_lsq(input logic [5:0] tag, input logic [31:0] addr,
                                        input logic [31:0] val);
        lsq_entry e;
        e.tag     = tag;
        e.address = addr;
        e.value   = val;
        return e;
    endfunction

    task automatic idle();
        rob_head = '0;
        lsq_head = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        sb_ready = 1'b0;
        idle();
        #2;
        $display("tx reset");
        check("rst_regwr", regwr, 2'b00);
        check("rst_victim", victim, 2'b00);
        check("rst_flush", flush, 1'b0);
        check("rst_redirect", redirect_pc, 32'h0);
        check("rst_sb_valid", sb_valid, 1'b0);
        check("rst_sb_empty", sb_empty, 1'b1);
        check("rst_rob_cnt", rob_retire_count, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("tx two ALU ops");
        rob_head[0] = mk_rob(1, 6'd1, 5'd5, 32'h11, 1, 0, 0, 0, 32'h0);
        rob_head[1] = mk_rob(1, 6'd2, 5'd6, 32'h22, 1, 0, 0, 0, 32'h0);
        #1;
        check("alu2_rob_cnt", rob_retire_count, 2'd2);
        check("alu2_lsq_cnt", lsq_retire_count, 2'd0);
        tick();
        check("alu2_regwr", regwr, 2'b11);
        check("alu2_rd", {rd[1], rd[0]}, {5'd6, 5'd5});
        check("alu2_value0", value[0], 32'h11);
        check("alu2_value1", value[1], 32'h22);
        check("alu2_victim", victim, 2'b11);

        $display("tx lane0 not ready");
        rob_head[0] = mk_rob(0, 6'd3, 5'd7, 32'h33, 1, 0, 0, 0, 32'h0);
        rob_head[1] = mk_rob(1, 6'd4, 5'd8, 32'h44, 1, 0, 0, 0, 32'h0);
        #1;
        check("inorder_rob_cnt", rob_retire_count, 2'd0);
        tick();
        check("inorder_regwr", regwr, 2'b00);

        $display("tx load tag mismatch");
        idle();
        rob_head[0] = mk_rob(1, 6'd3, 5'd7, 32'h33, 1, 0, 1, 0, 32'h0);
        rob_head[1] = mk_rob(1, 6'd4, 5'd8, 32'h44, 1, 0, 0, 0, 32'h0);
        lsq_head[0] = mk_lsq(6'd4, 32'h0, 32'h0);
        #1;
        check("tagmis_rob_cnt", rob_retire_count, 2'd0);
        check("tagmis_lsq_cnt", lsq_retire_count, 2'd0);

        $display("tx load + ALU");
        lsq_head[0] = mk_lsq(6'd3, 32'h0, 32'h0);
        #1;
        check("ldalu_rob_cnt", rob_retire_count, 2'd2);
        check("ldalu_lsq_cnt", lsq_retire_count, 2'd1);
        tick();
        check("ldalu_regwr", regwr, 2'b11);
        check("ldalu_rd1", rd[1], 5'd8);

        $display("tx ALU + store in lane1");
        idle();
        rob_head[0] = mk_rob(1, 6'd5, 5'd9, 32'h55, 1, 0, 0, 0, 32'h0);
        rob_head[1] = mk_rob(1, 6'd9, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        lsq_head[0] = mk_lsq(6'd9, 32'h300, 32'hCD);
        #1;
        check("alust_rob_cnt", rob_retire_count, 2'd2);
        check("alust_lsq_cnt", lsq_retire_count, 2'd1);
        tick();
        idle();
        check("alust_regwr", regwr, 2'b01);
        check("alust_sb_addr", sb_addr, 32'h300);
        check("alust_sb_data", sb_data, 32'hCD);
        sb_ready = 1'b1;
        tick();
        sb_ready = 1'b0;
        check("alust_drained", sb_empty, 1'b1);

        $display("tx store tag 7");
        rob_head[0] = mk_rob(1, 6'd7, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        lsq_head[0] = mk_lsq(6'd7, 32'h100, 32'hAB);
        #1;
        check("st_rob_cnt", rob_retire_count, 2'd1);
        check("st_lsq_cnt", lsq_retire_count, 2'd1);
        tick();
        idle();
        check("st_sb_valid", sb_valid, 1'b1);
        check("st_sb_addr", sb_addr, 32'h100);
        check("st_sb_data", sb_data, 32'hAB);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("st_hold_valid", sb_valid, 1'b1);
            check("st_hold_addr", sb_addr, 32'h100);
            check("st_hold_data", sb_data, 32'hAB);
        end
        sb_ready = 1'b1;
        tick();
        sb_ready = 1'b0;
        check("st_pop_empty", sb_empty, 1'b1);
        check("st_pop_valid", sb_valid, 1'b0);

        $display("tx fill store buffer");
        rob_head[0] = mk_rob(1, 6'd1, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        rob_head[1] = mk_rob(1, 6'd2, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        lsq_head[0] = mk_lsq(6'd1, 32'h200, 32'hD0);
        lsq_head[1] = mk_lsq(6'd2, 32'h204, 32'hD1);
        #1;
        check("fill1_rob_cnt", rob_retire_count, 2'd2);
        check("fill1_lsq_cnt", lsq_retire_count, 2'd2);
        tick();
        rob_head[0] = mk_rob(1, 6'd3, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        rob_head[1] = mk_rob(1, 6'd4, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        lsq_head[0] = mk_lsq(6'd3, 32'h208, 32'hD2);
        lsq_head[1] = mk_lsq(6'd4, 32'h20C, 32'hD3);
        #1;
        check("fill2_rob_cnt", rob_retire_count, 2'd2);
        tick();

        $display("tx store into full buffer");
        idle();
        rob_head[0] = mk_rob(1, 6'd5, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        lsq_head[0] = mk_lsq(6'd5, 32'h210, 32'hD4);
        #1;
        check("full_stall_cnt", rob_retire_count, 2'd0);
        tick();
        sb_ready = 1'b1;
        #1;
        check("full_pop_nopush", rob_retire_count, 2'd0);
        check("full_head0", sb_addr, 32'h200);
        tick();
        check("full_after_pop", rob_retire_count, 2'd1);
        check("full_head1", sb_addr, 32'h204);
        sb_ready = 1'b0;
        tick();
        idle();
        sb_ready = 1'b1;
        check("drain_204", sb_addr, 32'h204);
        tick();
        check("drain_208", sb_addr, 32'h208);
        tick();
        check("drain_20c", sb_addr, 32'h20C);
        tick();
        check("drain_210", sb_addr, 32'h210);
        check("drain_210_data", sb_data, 32'hD4);
        check("drain_210_valid", sb_valid, 1'b1);
        tick();
        sb_ready = 1'b0;
        check("drain_empty", sb_empty, 1'b1);

        $display("tx mispredict");
        rob_head[0] = mk_rob(1, 6'd6, 5'd3, 32'h33, 1, 0, 0, 1, 32'h40);
        rob_head[1] = mk_rob(1, 6'd7, 5'd4, 32'h44, 1, 0, 0, 0, 32'h0);
        #1;
        check("mp_rob_cnt", rob_retire_count, 2'd1);
        tick();
        check("mp_flush", flush, 1'b1);
        check("mp_redirect", redirect_pc, 32'h40);
        check("mp_regwr", regwr, 2'b01);
        check("mp_rd0", rd[0], 5'd3);
        check("mp_flush_nocommit", rob_retire_count, 2'd0);
        tick();
        idle();
        check("mp_flush_end", flush, 1'b0);
        check("mp_flush_regwr", regwr, 2'b00);

        $display("tx reset during flush");
        rob_head[0] = mk_rob(1, 6'd1, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        rob_head[1] = mk_rob(1, 6'd2, 5'd0, 32'h0, 0, 1, 0, 0, 32'h0);
        lsq_head[0] = mk_lsq(6'd1, 32'h500, 32'hE0);
        lsq_head[1] = mk_lsq(6'd2, 32'h504, 32'hE1);
        #1;
        check("rf_st_cnt", rob_retire_count, 2'd2);
        tick();
        idle();
        rob_head[0] = mk_rob(1, 6'd3, 5'd2, 32'h77, 1, 0, 0, 1, 32'h80);
        #1;
        check("rf_mp_cnt", rob_retire_count, 2'd1);
        tick();
        check("rf_in_flush", flush, 1'b1);
        check("rf_sb_valid", sb_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rf_flush", flush, 1'b0);
        check("rf_redirect", redirect_pc, 32'h0);
        check("rf_regwr", regwr, 2'b00);
        check("rf_victim", victim, 2'b00);
        check("rf_sb_valid0", sb_valid, 1'b0);
        check("rf_sb_empty", sb_empty, 1'b1);
        check("rf_sb_addr", sb_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle();
        rob_head[0] = mk_rob(1, 6'd4, 5'd9, 32'h99, 1, 0, 0, 0, 32'h0);
        #1;
        check("rf_run_cnt", rob_retire_count, 2'd1);
        tick();
        idle();
        check("rf_run_regwr", regwr, 2'b01);
        check("rf_run_value", value[0], 32'h99);
        check("rf_run_flush", flush, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/commit_unit.md
# commit_unit

Parametrised, multi-wide successor to the single-entry retire stage. Each cycle it commits up to `RETIRE_WIDTH` in-order entries from the ROB head window and dequeues matching LSQ entries. Committed stores go into an internal committed-store buffer, which drains to data memory through a valid/ready handshake. It also turns a committing mispredicted branch into a one-cycle pipeline flush with redirect.

## Interface
Parameters:
- `RETIRE_WIDTH`, 2: ROB/LSQ head-window lanes examined per cycle.
- `SB_DEPTH`, 4: committed-store buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rob_head`  in  rob_entry[RETIRE_WIDTH]  ROB window; lane 0 is the oldest. Fields used: `ready`, `tag`, `rd`, `value`, `ctrl_bits.regwr`, `ctrl_bits.memwr`, `ctrl_bits.memrd`, `mispredict`, `target`.
- `lsq_head`  in  lsq_entry[RETIRE_WIDTH]  LSQ window; lane 0 is the oldest. Fields used: `tag`, `address`, `value`.
- `regwr`  out  RETIRE_WIDTH  registered per-lane register-file write enable.
- `rd`  out  Register[RETIRE_WIDTH]  registered destination registers.
- `value`  out  MemoryWord[RETIRE_WIDTH]  registered write data.
- `victim`  out  RETIRE_WIDTH  registered; set for each lane that committed with `regwr`. Frees the old mapping.
- `rob_retire_count`  out  $clog2(RETIRE_WIDTH+1)  combinational count of ROB entries committed this cycle.
- `lsq_retire_count`  out  $clog2(RETIRE_WIDTH+1)  combinational count of LSQ entries dequeued this cycle.
- `flush`  out  1  registered one-cycle pulse.
- `redirect_pc`  out  MemoryWord  registered; valid while `flush`=1.
- `sb_valid`  out  1  store buffer has an entry at its head.
- `sb_addr`  out  MemoryWord  address of the buffer-head store.
- `sb_data`  out  MemoryWord  data of the buffer-head store.
- `sb_ready`  in  1  memory accepts the buffer head.
- `sb_empty`  out  1  store buffer occupancy is 0.

## Operation
- FSM with states RUN and FLUSH; reset enters RUN.
- In FLUSH: nothing commits, `flush`=1, next state is RUN.
- In RUN, lane i commits iff all of the following hold:
  - every lane j<i commits;
  - `rob_head[i].ready`;
  - no lane j<i commits with `mispredict`;
  - if the entry is a memory op, its LSQ slot tag equals `rob_head[i].tag`;
  - if it is a store, `sb_count` + stores committed in lanes <i is < `SB_DEPTH`.
- LSQ slot for lane i = number of memory ops committed in lanes <i.
- Tag mismatch on a memory op stalls that lane and all younger lanes.
- Committed store: pushes {`address`, `value`} of its LSQ entry into the store buffer, in lane order.
- Committed load: dequeues from the LSQ only.
- Counts:
  - `rob_retire_count` = number of lanes that commit.
  - `lsq_retire_count` = number of committed memory ops.
- Commit with `mispredict`:
  - the lane itself commits and writes the register file normally;
  - younger lanes are blocked;
  - next state is FLUSH and `redirect_pc` <= `target`.
- Store buffer:
  - circular FIFO with head/tail pointers that wrap modulo `SB_DEPTH`, plus a `$clog2(SB_DEPTH+1)` occupancy counter;
  - pop on `sb_valid && sb_ready`;
  - `sb_addr` and `sb_data` hold steady while `sb_valid && !sb_ready`;
  - flush does not clear the buffer, since its contents are architecturally committed.

## Timing
- Commit decision and both retire counts: same cycle, combinational.
- `regwr`, `rd`, `value`, `victim`: one cycle after commit.
- `flush` and `redirect_pc`: one cycle after the mispredict commits; `flush` lasts one cycle.
- Push to store buffer: a store committed in cycle N makes `sb_valid` high in N+1 when the buffer was empty.
- Full buffer with a pop in the same cycle: store-space check uses the registered count only. No push is allowed that cycle; the store commits the following cycle.
- Push and pop in the same cycle when not full: count unchanged and both pointers advance.
- Reset (async, any time, including mid-drain or mid-flush):
  - all registered outputs are 0;
  - store-buffer pointers and count are 0, so `sb_valid`=0 and `sb_empty`=1;
  - state is RUN.

## Structure
- Shared package:
  - `commit_state_t` (RUN, FLUSH);
  - `sb_entry` struct {MemoryWord addr, MemoryWord data};
  - `ctrl_bits` gains `memwr` and `memrd`;
  - `rob_entry` gains `mispredict` and `target`.
- Sub-module: `store_buffer` (parametrised FIFO with push vector, pop handshake, count, empty). It holds a FIFO of `SB_DEPTH` `sb_entry` entries.
- Lane-select logic and FSM live in `commit_unit`.

## Test plan
- Two ALU ops, both ready, with regwr=1, rd=5/6 and value=0x11/0x22:
  - `rob_retire_count`=2 and `lsq_retire_count`=0;
  - next cycle `regwr`=2'b11, `rd`={6,5}, `victim`=2'b11.
- Lane 0 not ready, lane 1 ready: count=0 and no writes (in-order commit).
- Lane 0 store tag 7 with LSQ tag 7, addr 0x100, data 0xAB:
  - commits with `lsq_retire_count`=1;
  - next cycle `sb_valid`=1, `sb_addr`=0x100, `sb_data`=0xAB;
  - `sb_ready`=0 for 3 cycles holds the outputs, then `sb_ready`=1 pops and `sb_empty`=1.
- Buffer full (4 entries), store at head, `sb_ready`=1:
  - store does not commit that cycle;
  - commits the next cycle, and count returns to 4.
- Lane 0 mispredict with target 0x40, lane 1 ready:
  - count=1;
  - next cycle `flush`=1 and `redirect_pc`=0x40 with no commits;
  - following cycle `flush`=0.
- Assert `reset` low while the buffer holds 2 entries during FLUSH: all outputs are 0 immediately, `sb_empty`=1, and the FSM restarts in RUN.
